// File: rtl/multi_channel_timer_if.sv
// Command, display-read and lap-FIFO bundle of multi_channel_timer.
// The UI layer is the master; the timer engine is the slave.
interface multi_channel_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int LAP_AW = 3
);
  logic              cmd_valid;
  logic [CH_W-1:0]   cmd_ch;
  logic [2:0]        cmd_op;
  logic              cmd_mode;
  logic [6:0]        cmd_hh;
  logic [5:0]        cmd_mm;
  logic [5:0]        cmd_ss;
  logic              cmd_err;

  logic [CH_W-1:0]   rd_ch;
  logic [6:0]        rd_hh;
  logic [5:0]        rd_mm;
  logic [5:0]        rd_ss;
  logic [1:0]        rd_state;
  logic              rd_mode;

  logic [NUM_CH-1:0] expired;
  logic [NUM_CH-1:0] expire_pulse;

  logic              lap_valid;
  logic              lap_rd_en;
  logic [CH_W-1:0]   lap_ch;
  logic [6:0]        lap_hh;
  logic [5:0]        lap_mm;
  logic [5:0]        lap_ss;
  logic [LAP_AW:0]   lap_count;
  logic              lap_overflow;

  modport master (
    output cmd_valid, cmd_ch, cmd_op, cmd_mode, cmd_hh, cmd_mm, cmd_ss, rd_ch, lap_rd_en,
    input  cmd_err, rd_hh, rd_mm, rd_ss, rd_state, rd_mode, expired, expire_pulse,
           lap_valid, lap_ch, lap_hh, lap_mm, lap_ss, lap_count, lap_overflow
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_op, cmd_mode, cmd_hh, cmd_mm, cmd_ss, rd_ch, lap_rd_en,
    output cmd_err, rd_hh, rd_mm, rd_ss, rd_state, rd_mode, expired, expire_pulse,
           lap_valid, lap_ch, lap_hh, lap_mm, lap_ss, lap_count, lap_overflow
  );
endinterface

// File: rtl/multi_channel_timer.sv
// Multi-channel HH:MM:SS stopwatch/countdown engine sharing one 1 s prescaler,
// with per-channel expiry flags and a shared first-word-fall-through lap FIFO.
module multi_channel_timer #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int TICK_DIV  = 100_000_000,
  parameter int MAX_HOURS = 99,
  parameter int LAP_DEPTH = 8,
  parameter int LAP_AW    = 3
) (
  input logic                  clk,
  input logic                  reset,
  multi_channel_timer_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = CH_W + 19;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam logic [2:0] OP_START   = 3'd0;
  localparam logic [2:0] OP_PAUSE   = 3'd1;
  localparam logic [2:0] OP_CLEAR   = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_LAP     = 3'd4;
  localparam logic [2:0] OP_SETMODE = 3'd5;

  logic [PW-1:0]     r_presc;
  logic              w_tick;

  logic [6:0]        r_hh  [NUM_CH];
  logic [5:0]        r_mm  [NUM_CH];
  logic [5:0]        r_ss  [NUM_CH];
  logic [6:0]        r_phh [NUM_CH];
  logic [5:0]        r_pmm [NUM_CH];
  logic [5:0]        r_pss [NUM_CH];
  logic [1:0]        r_state [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] r_expired;
  logic [NUM_CH-1:0] r_pulse;
  logic              r_err;

  logic [6:0]        w_up_hh [NUM_CH];
  logic [5:0]        w_up_mm [NUM_CH];
  logic [5:0]        w_up_ss [NUM_CH];
  logic [6:0]        w_dn_hh [NUM_CH];
  logic [5:0]        w_dn_mm [NUM_CH];
  logic [5:0]        w_dn_ss [NUM_CH];
  logic [NUM_CH-1:0] w_dn_zero;

  logic              w_ch_ok;
  logic [1:0]        w_sel_state;
  logic              w_sel_mode;
  logic [6:0]        w_sel_hh;
  logic [5:0]        w_sel_mm;
  logic [5:0]        w_sel_ss;
  logic              w_range_bad;
  logic              w_err;
  logic              w_take;
  logic              w_push;

  logic [EW-1:0]     r_mem [LAP_DEPTH];
  logic [LAP_AW-1:0] r_wp;
  logic [LAP_AW-1:0] r_rp;
  logic [LAP_AW:0]   r_cnt;
  logic              r_ovf;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Next value of every channel for both count directions; countdown saturates at zero.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_up_hh[c] = r_hh[c];
      w_up_mm[c] = r_mm[c];
      w_up_ss[c] = r_ss[c] + 6'd1;
      if (r_ss[c] == 6'd59) begin
        w_up_ss[c] = 6'd0;
        w_up_mm[c] = r_mm[c] + 6'd1;
        if (r_mm[c] == 6'd59) begin
          w_up_mm[c] = 6'd0;
          w_up_hh[c] = (r_hh[c] == 7'(MAX_HOURS)) ? 7'd0 : r_hh[c] + 7'd1;
        end
      end
      w_dn_hh[c] = r_hh[c];
      w_dn_mm[c] = r_mm[c];
      w_dn_ss[c] = r_ss[c];
      if (r_ss[c] != 6'd0) begin
        w_dn_ss[c] = r_ss[c] - 6'd1;
      end else if (r_mm[c] != 6'd0) begin
        w_dn_ss[c] = 6'd59;
        w_dn_mm[c] = r_mm[c] - 6'd1;
      end else if (r_hh[c] != 7'd0) begin
        w_dn_ss[c] = 6'd59;
        w_dn_mm[c] = 6'd59;
        w_dn_hh[c] = r_hh[c] - 7'd1;
      end
      w_dn_zero[c] = (w_dn_hh[c] == 7'd0) && (w_dn_mm[c] == 6'd0) && (w_dn_ss[c] == 6'd0);
    end
  end

  always_comb begin
    w_ch_ok     = 1'b0;
    w_sel_state = ST_IDLE;
    w_sel_mode  = 1'b0;
    w_sel_hh    = 7'd0;
    w_sel_mm    = 6'd0;
    w_sel_ss    = 6'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(bus.cmd_ch) == c) begin
        w_ch_ok     = 1'b1;
        w_sel_state = r_state[c];
        w_sel_mode  = r_mode[c];
        w_sel_hh    = r_hh[c];
        w_sel_mm    = r_mm[c];
        w_sel_ss    = r_ss[c];
      end
    end
  end

  assign w_range_bad = (bus.cmd_hh > 7'(MAX_HOURS)) || (bus.cmd_mm > 6'd59) || (bus.cmd_ss > 6'd59);

  always_comb begin
    w_err = 1'b0;
    if (bus.cmd_valid) begin
      if (!w_ch_ok) begin
        w_err = 1'b1;
      end else begin
        case (bus.cmd_op)
          OP_START:   w_err = (w_sel_state == ST_IDLE) && w_sel_mode &&
                              (w_sel_hh == 7'd0) && (w_sel_mm == 6'd0) && (w_sel_ss == 6'd0);
          OP_LOAD:    w_err = w_range_bad || (w_sel_state == ST_RUNNING) ||
                              (w_sel_state == ST_EXPIRED);
          OP_SETMODE: w_err = (w_sel_state != ST_IDLE);
          OP_PAUSE, OP_CLEAR, OP_LAP: w_err = 1'b0;
          default:    w_err = 1'b1;
        endcase
      end
    end
  end

  // A command "takes" a channel only when it changes it; only then does it swallow a coincident tick.
  always_comb begin
    w_take = 1'b0;
    w_push = 1'b0;
    if (bus.cmd_valid && !w_err) begin
      case (bus.cmd_op)
        OP_START:                    w_take = (w_sel_state != ST_RUNNING);
        OP_PAUSE:                    w_take = (w_sel_state == ST_RUNNING);
        OP_CLEAR, OP_LOAD, OP_SETMODE: w_take = 1'b1;
        OP_LAP:                      w_push = (w_sel_state == ST_RUNNING) || (w_sel_state == ST_PAUSED);
        default:                     w_take = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_hh[c]    <= 7'd0;
        r_mm[c]    <= 6'd0;
        r_ss[c]    <= 6'd0;
        r_phh[c]   <= 7'd0;
        r_pmm[c]   <= 6'd0;
        r_pss[c]   <= 6'd0;
        r_state[c] <= ST_IDLE;
      end
      r_mode    <= '0;
      r_expired <= '0;
      r_pulse   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err   <= w_err;
      r_pulse <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_take && int'(bus.cmd_ch) == c) begin
          case (bus.cmd_op)
            OP_START: begin
              if (r_state[c] == ST_EXPIRED) begin
                r_state[c]   <= ST_IDLE;
                r_hh[c]      <= r_phh[c];
                r_mm[c]      <= r_pmm[c];
                r_ss[c]      <= r_pss[c];
                r_expired[c] <= 1'b0;
              end else begin
                r_state[c] <= ST_RUNNING;
              end
            end
            OP_PAUSE: r_state[c] <= ST_PAUSED;
            OP_CLEAR: begin
              r_state[c]   <= ST_IDLE;
              r_expired[c] <= 1'b0;
              r_hh[c]      <= r_mode[c] ? r_phh[c] : 7'd0;
              r_mm[c]      <= r_mode[c] ? r_pmm[c] : 6'd0;
              r_ss[c]      <= r_mode[c] ? r_pss[c] : 6'd0;
            end
            OP_LOAD: begin
              r_hh[c]  <= bus.cmd_hh;
              r_mm[c]  <= bus.cmd_mm;
              r_ss[c]  <= bus.cmd_ss;
              r_phh[c] <= bus.cmd_hh;
              r_pmm[c] <= bus.cmd_mm;
              r_pss[c] <= bus.cmd_ss;
            end
            OP_SETMODE: begin
              r_mode[c] <= bus.cmd_mode;
              r_hh[c]   <= bus.cmd_mode ? r_phh[c] : 7'd0;
              r_mm[c]   <= bus.cmd_mode ? r_pmm[c] : 6'd0;
              r_ss[c]   <= bus.cmd_mode ? r_pss[c] : 6'd0;
            end
            default: ;
          endcase
        end else if (w_tick && r_state[c] == ST_RUNNING) begin
          if (r_mode[c]) begin
            r_hh[c] <= w_dn_hh[c];
            r_mm[c] <= w_dn_mm[c];
            r_ss[c] <= w_dn_ss[c];
            if (w_dn_zero[c]) begin
              r_state[c]   <= ST_EXPIRED;
              r_expired[c] <= 1'b1;
              r_pulse[c]   <= 1'b1;
            end
          end else begin
            r_hh[c] <= w_up_hh[c];
            r_mm[c] <= w_up_mm[c];
            r_ss[c] <= w_up_ss[c];
          end
        end
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is then not a drop.
  assign w_pop  = bus.lap_rd_en && (r_cnt != '0);
  assign w_full = (r_cnt == (LAP_AW + 1)'(LAP_DEPTH));
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAP_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {bus.cmd_ch, w_sel_hh, w_sel_mm, w_sel_ss};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_comb begin
    bus.rd_hh    = 7'd0;
    bus.rd_mm    = 6'd0;
    bus.rd_ss    = 6'd0;
    bus.rd_state = ST_IDLE;
    bus.rd_mode  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(bus.rd_ch) == c) begin
        bus.rd_hh    = r_hh[c];
        bus.rd_mm    = r_mm[c];
        bus.rd_ss    = r_ss[c];
        bus.rd_state = r_state[c];
        bus.rd_mode  = r_mode[c];
      end
    end
  end

  assign bus.cmd_err      = r_err;
  assign bus.expired      = r_expired;
  assign bus.expire_pulse = r_pulse;
  assign bus.lap_valid    = (r_cnt != '0);
  assign bus.lap_count    = r_cnt;
  assign bus.lap_overflow = r_ovf;
  assign {bus.lap_ch, bus.lap_hh, bus.lap_mm, bus.lap_ss} = r_mem[r_rp];
endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: a seconds-based reference model
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_multi_channel_timer;
  localparam int NUM_CH    = 4;
  localparam int CH_W      = 2;
  localparam int TICK_DIV  = 4;
  localparam int MAX_HOURS = 99;
  localparam int LAP_DEPTH = 8;
  localparam int LAP_AW    = 3;
  localparam int MAXT      = (MAX_HOURS + 1) * 3600;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
  localparam int OP_START = 0, OP_PAUSE = 1, OP_CLEAR = 2, OP_LOAD = 3, OP_LAP = 4, OP_SETMODE = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_channel_timer_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .LAP_AW(LAP_AW)) bus();

  multi_channel_timer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(TICK_DIV), .MAX_HOURS(MAX_HOURS),
    .LAP_DEPTH(LAP_DEPTH), .LAP_AW(LAP_AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each channel value is a plain count of seconds.
  typedef struct { int ch; int t; } lap_t;
  int   m_state [NUM_CH];
  bit   m_mode  [NUM_CH];
  int   m_t     [NUM_CH];
  int   m_pre   [NUM_CH];
  bit   m_exp   [NUM_CH];
  bit   m_pulse [NUM_CH];
  bit   m_err;
  int   m_presc;
  int   m_ticks = 0;
  lap_t m_q [$];
  bit   m_ovf;
  bit   m_live = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit   tick, push, pop, full, err;
    bit   taken [NUM_CH];
    lap_t ent;
    int   c, op, reqt;
    tick    = (m_presc == TICK_DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    if (tick) m_ticks++;
    err = 0; push = 0; ent.ch = 0; ent.t = 0;
    for (int i = 0; i < NUM_CH; i++) begin taken[i] = 0; m_pulse[i] = 0; end
    if (bus.cmd_valid) begin
      c    = int'(bus.cmd_ch);
      op   = int'(bus.cmd_op);
      reqt = int'(bus.cmd_hh) * 3600 + int'(bus.cmd_mm) * 60 + int'(bus.cmd_ss);
      if (c >= NUM_CH || op > OP_SETMODE) err = 1;
      else case (op)
        OP_START: begin
          if (m_state[c] == S_IDLE) begin
            if (m_mode[c] && m_t[c] == 0) err = 1;
            else begin m_state[c] = S_RUN; taken[c] = 1; end
          end else if (m_state[c] == S_PAUSE) begin
            m_state[c] = S_RUN; taken[c] = 1;
          end else if (m_state[c] == S_EXP) begin
            m_state[c] = S_IDLE; m_t[c] = m_pre[c]; m_exp[c] = 0; taken[c] = 1;
          end
        end
        OP_PAUSE: if (m_state[c] == S_RUN) begin m_state[c] = S_PAUSE; taken[c] = 1; end
        OP_CLEAR: begin
          m_state[c] = S_IDLE; m_t[c] = m_mode[c] ? m_pre[c] : 0; m_exp[c] = 0; taken[c] = 1;
        end
        OP_LOAD: begin
          if (bus.cmd_hh > MAX_HOURS || bus.cmd_mm > 59 || bus.cmd_ss > 59 ||
              m_state[c] == S_RUN || m_state[c] == S_EXP) err = 1;
          else begin m_pre[c] = reqt; m_t[c] = reqt; taken[c] = 1; end
        end
        OP_LAP: if (m_state[c] == S_RUN || m_state[c] == S_PAUSE) begin
          push = 1; ent.ch = c; ent.t = m_t[c];
        end
        default: begin
          if (m_state[c] != S_IDLE) err = 1;
          else begin m_mode[c] = bus.cmd_mode; m_t[c] = m_mode[c] ? m_pre[c] : 0; taken[c] = 1; end
        end
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!taken[i] && tick && m_state[i] == S_RUN) begin
        if (m_mode[i]) begin
          if (m_t[i] > 0) m_t[i]--;
          if (m_t[i] == 0) begin m_state[i] = S_EXP; m_exp[i] = 1; m_pulse[i] = 1; end
        end else begin
          m_t[i] = (m_t[i] + 1) % MAXT;
        end
      end
    end
    full = (m_q.size() == LAP_DEPTH);
    pop  = bus.lap_rd_en && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (full && !pop) m_ovf = 1;
      else m_q.push_back(ent);
    end
    m_err = err;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_state[i] = S_IDLE; m_mode[i] = 0; m_t[i] = 0; m_pre[i] = 0; m_exp[i] = 0; m_pulse[i] = 0;
      end
      m_err = 0; m_presc = 0; m_q.delete(); m_ovf = 0; m_live = 1;
    end else if (m_live) begin
      modelStep();
    end
  end

  task automatic compareAll();
    int r, e, p;
    r = int'(bus.rd_ch);
    e = 0; p = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_exp[i])   e |= (1 << i);
      if (m_pulse[i]) p |= (1 << i);
    end
    checkOutput("cmd_err", bus.cmd_err, m_err);
    checkOutput("rd_hh", bus.rd_hh, m_t[r] / 3600);
    checkOutput("rd_mm", bus.rd_mm, (m_t[r] / 60) % 60);
    checkOutput("rd_ss", bus.rd_ss, m_t[r] % 60);
    checkOutput("rd_state", bus.rd_state, m_state[r]);
    checkOutput("rd_mode", bus.rd_mode, m_mode[r]);
    checkOutput("expired", bus.expired, e);
    checkOutput("expire_pulse", bus.expire_pulse, p);
    checkOutput("lap_valid", bus.lap_valid, (m_q.size() > 0) ? 1 : 0);
    checkOutput("lap_count", bus.lap_count, m_q.size());
    checkOutput("lap_overflow", bus.lap_overflow, m_ovf);
    if (m_q.size() > 0) begin
      checkOutput("lap_ch", bus.lap_ch, m_q[0].ch);
      checkOutput("lap_hh", bus.lap_hh, m_q[0].t / 3600);
      checkOutput("lap_mm", bus.lap_mm, (m_q[0].t / 60) % 60);
      checkOutput("lap_ss", bus.lap_ss, m_q[0].t % 60);
    end
  endtask

  always @(negedge clk) if (m_live) compareAll();

  task automatic applyStimulus(input bit valid, input int op, input int ch,
                               input int hh = 0, input int mm = 0, input int ss = 0,
                               input bit mode = 0, input bit pop = 0);
    bus.cmd_valid = valid;
    bus.cmd_op    = 3'(op);
    bus.cmd_ch    = CH_W'(ch);
    bus.cmd_hh    = 7'(hh);
    bus.cmd_mm    = 6'(mm);
    bus.cmd_ss    = 6'(ss);
    bus.cmd_mode  = mode;
    bus.lap_rd_en = pop;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.lap_rd_en = 1'b0;
  endtask

  task automatic waitTicks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = n * TICK_DIV + 8;
    while (m_ticks < target && budget > 0) begin @(posedge clk); #1; budget--; end
    if (m_ticks < target) begin
      n_errors++;
      $display("[TB] FAIL tick_wait: got %0d ticks, expected %0d", m_ticks, target);
    end
  endtask

  task automatic alignToTick();
    int budget;
    budget = 2 * TICK_DIV;
    while (m_presc != TICK_DIV - 1 && budget > 0) begin @(posedge clk); #1; budget--; end
    if (m_presc != TICK_DIV - 1) begin
      n_errors++;
      $display("[TB] FAIL tick_align: got presc %0d, expected %0d", m_presc, TICK_DIV - 1);
    end
  endtask

  task automatic checkRd(input string tag, input int hh, input int mm, input int ss, input int st);
    checkOutput({tag, "_hh"}, bus.rd_hh, hh);
    checkOutput({tag, "_mm"}, bus.rd_mm, mm);
    checkOutput({tag, "_ss"}, bus.rd_ss, ss);
    checkOutput({tag, "_state"}, bus.rd_state, st);
  endtask

  initial begin
    bus.cmd_valid = 0; bus.cmd_ch = '0; bus.cmd_op = '0; bus.cmd_mode = 0;
    bus.cmd_hh = '0; bus.cmd_mm = '0; bus.cmd_ss = '0; bus.rd_ch = '0; bus.lap_rd_en = 0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkRd("reset_rd", 0, 0, 0, S_IDLE);
    checkOutput("reset_lap_count", bus.lap_count, 0);
    checkOutput("reset_cmd_err", bus.cmd_err, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // ch0 stopwatch: 61 ticks gives 00:01:01, then a lap of that value.
    applyStimulus(1, OP_START, 0);
    waitTicks(61);
    @(negedge clk);
    checkRd("sw61", 0, 1, 1, S_RUN);
    applyStimulus(1, OP_LAP, 0);
    @(negedge clk);
    checkOutput("lap1_valid", bus.lap_valid, 1);
    checkOutput("lap1_ch", bus.lap_ch, 0);
    checkOutput("lap1_mm", bus.lap_mm, 1);
    checkOutput("lap1_ss", bus.lap_ss, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // ch2 countdown from 3 s down to expiry, then CLEAR restores the preset.
    bus.rd_ch = 2'd2;
    applyStimulus(1, OP_LOAD, 2, 0, 0, 3);
    applyStimulus(1, OP_SETMODE, 2, 0, 0, 0, 1);
    applyStimulus(1, OP_START, 2);
    waitTicks(1); @(negedge clk); checkRd("cd2", 0, 0, 2, S_RUN);
    waitTicks(1); @(negedge clk); checkRd("cd1", 0, 0, 1, S_RUN);
    waitTicks(1); @(negedge clk); checkRd("cd0", 0, 0, 0, S_EXP);
    checkOutput("exp_pulse_on", bus.expire_pulse, 4);
    checkOutput("expired_set", bus.expired, 4);
    @(negedge clk);
    checkOutput("exp_pulse_off", bus.expire_pulse, 0);
    checkOutput("expired_held", bus.expired, 4);
    applyStimulus(1, OP_CLEAR, 2);
    @(negedge clk);
    checkRd("cd_clear", 0, 0, 3, S_IDLE);
    checkOutput("expired_clr", bus.expired, 0);

    // Rejected commands: bad minutes, LOAD while running, reserved opcode.
    bus.rd_ch = 2'd1;
    applyStimulus(1, OP_LOAD, 1, 0, 60, 0);
    @(negedge clk); checkOutput("err_mm60", bus.cmd_err, 1); checkRd("err_mm60", 0, 0, 0, S_IDLE);
    @(negedge clk); checkOutput("err_pulse_end", bus.cmd_err, 0);
    applyStimulus(1, OP_LOAD, 0, 1, 1, 1);
    @(negedge clk); checkOutput("err_load_run", bus.cmd_err, 1);
    applyStimulus(1, 7, 1);
    @(negedge clk); checkOutput("err_op7", bus.cmd_err, 1);

    // Stopwatch wrap at 99:59:59.
    bus.rd_ch = 2'd3;
    applyStimulus(1, OP_LOAD, 3, 99, 59, 58);
    applyStimulus(1, OP_START, 3);
    waitTicks(1); @(negedge clk); checkRd("wrap_a", 99, 59, 59, S_RUN);
    waitTicks(1); @(negedge clk); checkRd("wrap_b", 0, 0, 0, S_RUN);

    // Lap FIFO overflow, then push+pop while full.
    for (int i = 0; i < 9; i++) applyStimulus(1, OP_LAP, 0);
    @(negedge clk);
    checkOutput("fifo_count_full", bus.lap_count, 8);
    checkOutput("fifo_overflow", bus.lap_overflow, 1);
    checkOutput("fifo_head_ch", bus.lap_ch, 0);
    applyStimulus(1, OP_LAP, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("fifo_pushpop_count", bus.lap_count, 8);
    checkOutput("fifo_overflow_held", bus.lap_overflow, 1);

    // PAUSE coinciding with a tick freezes the pre-tick value.
    bus.rd_ch = 2'd1;
    applyStimulus(1, OP_LOAD, 1, 0, 0, 10);
    applyStimulus(1, OP_START, 1);
    waitTicks(2); @(negedge clk); checkRd("pause_pre", 0, 0, 12, S_RUN);
    alignToTick();
    applyStimulus(1, OP_PAUSE, 1);
    @(negedge clk); checkRd("pause_tick", 0, 0, 12, S_PAUSE);
    waitTicks(2); @(negedge clk); checkRd("pause_hold", 0, 0, 12, S_PAUSE);

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checkRd("async_rst", 0, 0, 0, S_IDLE);
    checkOutput("async_rst_lap_count", bus.lap_count, 0);
    checkOutput("async_rst_lap_valid", bus.lap_valid, 0);
    checkOutput("async_rst_ovf", bus.lap_overflow, 0);
    checkOutput("async_rst_expired", bus.expired, 0);
    checkOutput("async_rst_pulse", bus.expire_pulse, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
